// File: rtl/efuse_load_ctrl.sv
// Efuse load controller: requests a load from the efuse IP, captures the image,
// validates it with an XOR checksum and publishes trim data, with timeout and bounded retry.
module efuse_load_ctrl #(
    parameter int DATA_NUM    = 8,
    parameter int DW          = 8,
    parameter int TIMEOUT_CYC = 64,
    parameter int MAX_RETRY   = 2,
    parameter int CHK_EN      = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    output logic                   o_efuse_load_req,
    input  logic                   i_efuse_load_done,
    input  logic                   i_efuse_reg_update,
    input  logic [DATA_NUM*DW-1:0] i_efuse_reg_data,
    input  logic                   i_reload_req,
    output logic                   o_load_busy,
    output logic                   o_load_ok,
    output logic                   o_load_err,
    output logic                   o_trim_vld,
    output logic [DATA_NUM*DW-1:0] o_trim_data
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_CHECK, S_BACKOFF, S_DONE, S_ERR
    } state_t;

    state_t                   state;
    logic [DATA_NUM*DW-1:0]   cap_reg;
    logic [DATA_NUM*DW-1:0]   trim_q;
    logic [RW-1:0]            retry_cnt;
    logic [TW-1:0]            tmo_cnt;
    logic                     reload_pend;
    logic                     req_q;
    logic                     busy_q;
    logic                     ok_q;
    logic                     err_q;
    logic                     vld_q;

    logic [DW-1:0]            chk_xor;
    logic                     chk_pass;
    logic                     can_retry;
    logic                     tmo_hit;

    always_comb begin
        chk_xor = '0;
        for (int i = 0; i < DATA_NUM; i++) begin
            chk_xor = chk_xor ^ cap_reg[i*DW +: DW];
        end
    end

    assign chk_pass  = (CHK_EN == 0) || (chk_xor == '0);
    assign can_retry = retry_cnt < RW'(MAX_RETRY);
    assign tmo_hit   = tmo_cnt == TW'(TIMEOUT_CYC - 1);

    // The request is a level held for the whole REQ window; the IP answers with a done level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            cap_reg     <= '0;
            trim_q      <= '0;
            retry_cnt   <= '0;
            tmo_cnt     <= '0;
            reload_pend <= 1'b1;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            vld_q       <= 1'b0;
        end else begin
            ok_q <= 1'b0;
            if (i_reload_req) reload_pend <= 1'b1;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (state == S_IDLE) busy_q <= 1'b1;
                    if (reload_pend && !i_efuse_load_done) begin
                        state       <= S_REQ;
                        reload_pend <= i_reload_req;
                        err_q       <= 1'b0;
                        retry_cnt   <= '0;
                        tmo_cnt     <= '0;
                        req_q       <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_REQ: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (i_efuse_reg_update) cap_reg <= i_efuse_reg_data;
                    if (i_efuse_load_done) begin
                        state <= S_CHECK;
                        req_q <= 1'b0;
                    end else if (tmo_hit) begin
                        req_q <= 1'b0;
                        if (can_retry) begin
                            retry_cnt <= retry_cnt + RW'(1);
                            tmo_cnt   <= '0;
                            state     <= S_BACKOFF;
                        end else begin
                            state  <= S_ERR;
                            err_q  <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    end
                end
                S_CHECK: begin
                    if (chk_pass) begin
                        state     <= S_DONE;
                        trim_q    <= cap_reg;
                        vld_q     <= 1'b1;
                        ok_q      <= 1'b1;
                        retry_cnt <= '0;
                        busy_q    <= 1'b0;
                    end else if (can_retry) begin
                        retry_cnt <= retry_cnt + RW'(1);
                        tmo_cnt   <= '0;
                        state     <= S_BACKOFF;
                    end else begin
                        state  <= S_ERR;
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                S_BACKOFF: begin
                    // Let the IP drop done before re-requesting so a stale done is not mistaken.
                    if (!i_efuse_load_done) begin
                        state   <= S_REQ;
                        tmo_cnt <= '0;
                        req_q   <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_efuse_load_req = req_q;
    assign o_load_busy      = busy_q;
    assign o_load_ok        = ok_q;
    assign o_load_err       = err_q;
    assign o_trim_vld       = vld_q;
    assign o_trim_data      = trim_q;

endmodule

// File: tb/tb_efuse_load_ctrl.sv
// Bench for efuse_load_ctrl: an efuse IP model with per-attempt response control,
// an attempt-level reference model feeding an expected queue, and a decoupled monitor.
module tb_efuse_load_ctrl;

    localparam int DATA_NUM    = 8;
    localparam int DW          = 8;
    localparam int TIMEOUT_CYC = 64;
    localparam int MAX_RETRY   = 2;
    localparam int CHK_EN      = 1;
    localparam int W           = DATA_NUM * DW;
    localparam int QW          = W + 1;

    logic         clk;
    logic         rst_n;
    logic         efuse_req;
    logic         efuse_done;
    logic         efuse_upd;
    logic [W-1:0] ip_data;
    logic         reload;
    logic         busy;
    logic         load_ok;
    logic         load_err;
    logic         trim_vld;
    logic [W-1:0] trim_data;

    efuse_load_ctrl #(
        .DATA_NUM(DATA_NUM), .DW(DW), .TIMEOUT_CYC(TIMEOUT_CYC),
        .MAX_RETRY(MAX_RETRY), .CHK_EN(CHK_EN)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .o_efuse_load_req(efuse_req),
        .i_efuse_load_done(efuse_done),
        .i_efuse_reg_update(efuse_upd),
        .i_efuse_reg_data(ip_data),
        .i_reload_req(reload),
        .o_load_busy(busy),
        .o_load_ok(load_ok),
        .o_load_err(load_err),
        .o_trim_vld(trim_vld),
        .o_trim_data(trim_data)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- checking primitives ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- efuse IP model ----------------
    // Behaves like a registered IP: done/update follow the request by one cycle,
    // but only on attempts whose bit is set in ip_mask (attempts counted from ip_base).
    logic [7:0] ip_mask;
    int         ip_base;
    int         rise_cnt;
    int         cur_att;
    logic       req_d;

    initial begin
        efuse_done = 1'b0;
        efuse_upd  = 1'b0;
        rise_cnt   = 0;
        cur_att    = 0;
        req_d      = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                efuse_done = 1'b0;
                efuse_upd  = 1'b0;
                req_d      = 1'b0;
            end else begin
                efuse_done = req_d && (cur_att >= 0) && (cur_att < 8) && ip_mask[cur_att[2:0]];
                efuse_upd  = efuse_done;
                if (efuse_req && !req_d) begin
                    cur_att = rise_cnt - ip_base;
                    rise_cnt++;
                end
                req_d = efuse_req;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [QW-1:0] exp_q[$];
    logic [W-1:0]  last_good;

    function automatic logic [DW-1:0] img_xor(input logic [W-1:0] d);
        logic [DW-1:0] x;
        x = '0;
        for (int i = 0; i < DATA_NUM; i++) x = x ^ d[i*DW +: DW];
        return x;
    endfunction

    // Outcome of one load: the first responding attempt with a clean image wins.
    function automatic logic [QW-1:0] model_load(input logic [7:0] mask, input logic [W-1:0] d);
        for (int a = 0; a <= MAX_RETRY; a++) begin
            if (mask[a[2:0]] && (CHK_EN == 0 || img_xor(d) == '0)) begin
                last_good = d;
                return {1'b0, d};
            end
        end
        return {1'b1, last_good};
    endfunction

    function automatic int model_attempts(input logic [7:0] mask, input logic [W-1:0] d);
        if (CHK_EN != 0 && img_xor(d) != '0) return MAX_RETRY + 1;
        for (int a = 0; a <= MAX_RETRY; a++) begin
            if (mask[a[2:0]]) return a + 1;
        end
        return MAX_RETRY + 1;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [QW-1:0] ev;
    logic          prev_err;
    logic          vld_seen;

    initial begin
        prev_err = 1'b0;
        vld_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_err = 1'b0;
                vld_seen = 1'b0;
            end else begin
                if (load_ok || (load_err && !prev_err)) begin
                    if (exp_q.size() == 0) begin
                        chk_bit("unexpected_event", 1'b1, 1'b0);
                    end else begin
                        ev = exp_q.pop_front();
                        if (load_ok) begin
                            chk_bit("event_kind_ok", 1'b0, ev[W]);
                            chk("ok_trim_data", trim_data, ev[W-1:0]);
                            chk_bit("ok_trim_vld", trim_vld, 1'b1);
                            chk_bit("ok_err_low", load_err, 1'b0);
                            vld_seen = 1'b1;
                        end else begin
                            chk_bit("event_kind_err", 1'b1, ev[W]);
                            chk("err_trim_data", trim_data, ev[W-1:0]);
                            chk_bit("err_trim_vld", trim_vld, vld_seen);
                            chk_bit("err_busy_low", busy, 1'b0);
                        end
                    end
                end
                if (vld_seen) chk_bit("trim_vld_sticky", trim_vld, 1'b1);
                prev_err = load_err;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload();
        tick();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic start_load(input logic [7:0] mask, input logic [W-1:0] d);
        ip_mask = mask;
        ip_data = d;
        ip_base = rise_cnt;
        exp_q.push_back(model_load(mask, d));
        pulse_reload();
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || busy || efuse_req) && c < 2000) begin
            tick();
            c++;
        end
        chk_bit({name, "_timeout"}, c < 2000, 1'b1);
    endtask

    task automatic wait_req(input string name);
        int c;
        c = 0;
        while (!efuse_req && c < 20) begin
            tick();
            c++;
        end
        chk_bit({name, "_req_seen"}, efuse_req, 1'b1);
    endtask

    task automatic chk_all_zero(input string name);
        chk_bit({name, "_req"}, efuse_req, 1'b0);
        chk_bit({name, "_busy"}, busy, 1'b0);
        chk_bit({name, "_ok"}, load_ok, 1'b0);
        chk_bit({name, "_err"}, load_err, 1'b0);
        chk_bit({name, "_vld"}, trim_vld, 1'b0);
        chk({name, "_trim"}, trim_data, '0);
    endtask

    // Releases reset and checks the automatic load against the documented edge timing.
    task automatic auto_load_after_reset(input string name);
        ip_mask = 8'hFF;
        ip_data = '0;
        ip_base = rise_cnt;
        last_good = '0;
        exp_q.push_back(model_load(8'hFF, '0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_bit({name, "_e1_req"}, efuse_req, 1'b1);
        chk_bit({name, "_e1_busy"}, busy, 1'b1);
        chk_bit({name, "_e1_vld"}, trim_vld, 1'b0);
        tick();
        chk_bit({name, "_e2_req"}, efuse_req, 1'b1);
        tick();
        chk_bit({name, "_e3_req"}, efuse_req, 1'b0);
        chk_bit({name, "_e3_ok"}, load_ok, 1'b0);
        tick();
        chk_bit({name, "_e4_ok"}, load_ok, 1'b1);
        chk_bit({name, "_e4_vld"}, trim_vld, 1'b1);
        chk({name, "_e4_trim"}, trim_data, '0);
        chk_bit({name, "_e4_err"}, load_err, 1'b0);
        wait_idle(name);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] d;
        logic [7:0]   m;
        int           a0;
        int           lo;
        int           hi;

        rst_n   = 1'b0;
        reload  = 1'b0;
        ip_mask = 8'hFF;
        ip_data = '0;
        ip_base = 0;
        last_good = '0;

        // 1: reset state and automatic load timing
        tick();
        chk_all_zero("reset");
        tick();
        auto_load_after_reset("auto");

        // 2: clean image published, then a corrupt image exhausts all attempts
        start_load(8'hFF, 64'h0102030000000000);
        wait_idle("good_img");
        chk("good_img_trim", trim_data, 64'h0102030000000000);
        start_load(8'hFF, 64'h0100000000000000);
        wait_idle("bad_img");
        chk_int("bad_img_attempts", rise_cnt - ip_base, MAX_RETRY + 1);
        chk_bit("bad_img_err", load_err, 1'b1);

        // 3: IP never answers: three full request windows separated by a backoff cycle
        d = 64'h1122330000000000;
        ip_mask = 8'h00;
        ip_data = d;
        ip_base = rise_cnt;
        exp_q.push_back(model_load(8'h00, d));
        pulse_reload();
        for (int w = 0; w < MAX_RETRY + 1; w++) begin
            lo = 0;
            hi = 0;
            while (!efuse_req && lo < 20) begin
                tick();
                lo++;
            end
            if (w > 0) chk_int("backoff_gap", lo, 1);
            while (efuse_req && hi < 200) begin
                tick();
                hi++;
            end
            chk_int("req_window_len", hi, TIMEOUT_CYC);
        end
        chk_bit("tmo_err_set", load_err, 1'b1);
        chk_bit("tmo_busy_low", busy, 1'b0);
        wait_idle("tmo");

        // 4: answer only on the 2nd attempt; error clears when the new load starts
        start_load(8'b0000_0010, 64'h5500000000000055);
        wait_req("late_done");
        chk_bit("err_cleared_on_start", load_err, 1'b0);
        wait_idle("late_done");
        chk_int("late_done_attempts", rise_cnt - ip_base, 2);
        chk_bit("late_done_err", load_err, 1'b0);
        // success on the 3rd attempt is only reachable if the retry count was reset
        start_load(8'b0000_0100, 64'h0000A50000A50000);
        wait_idle("retry_reset");
        chk_int("retry_reset_attempts", rise_cnt - ip_base, 3);

        // 5: two reload pulses inside one long REQ window coalesce into one extra load
        d = 64'h0F0F000000000000;
        ip_mask = 8'hFE;
        ip_data = d;
        ip_base = rise_cnt;
        exp_q.push_back(model_load(8'hFE, d));
        exp_q.push_back(model_load(8'hFF, d));
        pulse_reload();
        wait_req("coalesce");
        repeat (3) tick();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        repeat (3) tick();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk_bit("coalesce_vld_kept", trim_vld, 1'b1);
        wait_idle("coalesce");
        chk_int("coalesce_attempts", rise_cnt - ip_base, 3);

        // randomized loads
        for (int t = 0; t < 10; t++) begin
            m = {5'b0, 3'($urandom_range(0, 7))};
            d = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                d[W-1 -: DW] = '0;
                d[W-1 -: DW] = img_xor(d);
            end
            a0 = model_attempts(m, d);
            start_load(m, d);
            wait_idle("rand");
            chk_int("rand_attempts", rise_cnt - ip_base, a0);
        end

        // 6: reset during REQ drops everything at once, then the automatic load repeats
        start_load(8'hFF, 64'h0202000000000000);
        wait_idle("pre_reset");
        d = 64'h0303000000000000;
        ip_mask = 8'hFF;
        ip_data = d;
        ip_base = rise_cnt;
        pulse_reload();
        wait_req("mid_reset");
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        exp_q.delete();
        repeat (2) tick();
        auto_load_after_reset("re_auto");

        chk_int("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/efuse_load_ctrl.md
Name: efuse_load_ctrl

Overview:
Load controller that sits directly upstream of the efuse IP. After reset, or on a reload request, it drives the efuse load request and captures the efuse register image. It then checks the image with an XOR checksum and publishes validated trim data to the chip. It handles a missing or late load-done with a timeout, and bounds the number of retries.

Parameters:
DATA_NUM, 8, number of efuse words (must match the efuse IP).
DW, 8, bits per efuse word.
TIMEOUT_CYC, 64, cycles allowed in REQ before an attempt fails (>=2).
MAX_RETRY, 2, retries after the first failed attempt; total attempts = MAX_RETRY+1.
CHK_EN, 1, 1: the XOR of all DATA_NUM words must equal 0; 0: no check.

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
o_efuse_load_req  output  1  load request level to the efuse IP
i_efuse_load_done  input  1  load done level from the efuse IP
i_efuse_reg_update  input  1  efuse data valid strobe
i_efuse_reg_data  input  DATA_NUM*DW  efuse register image
i_reload_req  input  1  single-cycle pulse requesting a new load
o_load_busy  output  1  high while the state is not DONE or ERR
o_load_ok  output  1  one-cycle pulse on successful load
o_load_err  output  1  sticky error level; cleared only when a new attempt starts
o_trim_vld  output  1  high once any load has succeeded
o_trim_data  output  DATA_NUM*DW  last validated image

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is asynchronous active-low on i_rst_n. All flops are cleared by reset.
- Reset values:
  - state=IDLE.
  - All outputs 0, including o_trim_data.
  - Capture register 0, retry_cnt=0, tmo_cnt=0.
  - reload_pend=1, so an automatic load runs after reset.
- All outputs are registered or decoded from state. There is no combinational path from input to output.
- IDLE:
  - If reload_pend is set and i_efuse_load_done=0, go to REQ, clear reload_pend and clear o_load_err.
  - If i_efuse_load_done=1, stay in IDLE.
- REQ:
  - o_efuse_load_req=1; tmo_cnt increments each cycle.
  - When i_efuse_reg_update=1, the capture register loads i_efuse_reg_data on that edge. A later strobe overwrites an earlier one.
  - When i_efuse_load_done=1 is sampled, go to CHECK and drop the request.
  - The capture register also loads on that same edge if i_efuse_reg_update=1.
- Timeout:
  - When tmo_cnt==TIMEOUT_CYC-1 and done=0, the attempt fails.
  - Done sampled on the same edge as the timeout wins: the attempt is not treated as a failure.
- CHECK (one cycle):
  - Computes the XOR of all DW-bit words of the capture register.
  - Pass (zero, or CHK_EN=0): go to DONE. On that edge o_trim_data is set to the capture register, o_trim_vld=1, o_load_ok=1 for exactly one cycle, and retry_cnt=0.
  - Fail: the attempt fails.
- Failed attempt:
  - If retry_cnt<MAX_RETRY: retry_cnt++, tmo_cnt=0, go to BACKOFF.
  - Otherwise: go to ERR and set o_load_err=1. o_trim_data and o_trim_vld stay unchanged.
- BACKOFF:
  - Request is low; wait for i_efuse_load_done=0.
  - Then go to REQ with tmo_cnt=0.
- DONE and ERR:
  - Idle terminal states.
  - An i_reload_req pulse sets reload_pend. The next edge with done=0 goes to REQ with retry_cnt=0 and o_load_err cleared.
- Reload requests:
  - i_reload_req is latched in any state.
  - In the busy states (REQ/CHECK/BACKOFF) it sets reload_pend, which is serviced after reaching DONE or ERR.
  - Multiple pulses coalesce into a single reload.
- During a reload, o_trim_data and o_trim_vld keep their old values until the next successful CHECK.
- Reset mid-operation: the request drops asynchronously and the automatic load restarts after reset is released.
- Expected timing with an efuse IP whose done/update follow the request by one cycle:
  - Edge 1 after reset release: REQ.
  - Edge 3: CHECK.
  - Edge 4: o_trim_vld=1 and o_load_ok pulse.

Test Plan:
1. Reset release, IP model returns done and update 1 cycle after the request with all-zero data → request high for 2 cycles; o_load_ok pulse and o_trim_vld=1 at the 4th edge; o_trim_data=0; o_load_err=0.
2. Data 0x01_02_03_00_00_00_00_00 (XOR=0) → o_trim_data equals the data. Then data 0x01_00..00 (XOR≠0) with CHK_EN=1 → 3 attempts, then o_load_err=1 and o_trim_data still holds the previous value.
3. IP never asserts done, TIMEOUT_CYC=64, MAX_RETRY=2 → three request windows of 64 cycles each, separated by BACKOFF; o_load_err=1 after the third; o_load_busy falls with it.
4. Done arrives only on the 2nd attempt → one timeout, then success; o_load_err stays 0 and retry_cnt returns to 0.
5. i_reload_req pulsed twice during REQ → exactly one extra load after DONE; o_trim_vld stays 1 throughout.
6. Reset asserted while in REQ → o_efuse_load_req drops immediately and all outputs read 0. After release, the automatic load repeats scenario 1 timing.
